timer_seq_master: RTL
=====================

# timer_seq_master

- Avalon-MM initiator that drives the 16-bit interval-timer register slave on behalf of hardware logic without CPU involvement.
- Accepts one-shot commands on a valid/ready port: program period, start, stop, snapshot, read status, clear timeout.
- Each command is expanded into the required register write/read sequence; exactly one response is returned per command.
- Sits between user datapath logic and the timer's s1 slave port.

## Interface
- CTRL_CONT, 1, value written to control bit 1 (continuous) on START/STOP
- CTRL_ITO, 1, value written to control bit 0 (interrupt enable) on START/STOP
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE (and no IRQ ack pending, see Configuration)
- cmd_op  in  3  0 PROGRAM, 1 START, 2 STOP, 3 SNAPSHOT, 4 STATUS, 5 CLEAR, 6–7 illegal
- cmd_period  in  32  period for PROGRAM
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_data  out  32  SNAPSHOT: counter value; STATUS: {30'b0, running, timeout}; otherwise 0
- rsp_err  out  1  set for illegal op
- address  out  3  slave register address
- chipselect  out  1  slave select
- write_n  out  1  active-low write
- writedata  out  16  write data
- readdata  in  16  slave read data, fixed latency 1, no waitrequest

## Operation
- States: IDLE, WR_PL, WR_PH, WR_CTRL, WR_SNAP, RD_SL, RD_SH, RD_CAP, RD_ST, WR_ST, RSP.
- Accept on the edge where cmd_valid && cmd_ready; cmd_op/cmd_period latched there.
- PROGRAM: WR_PL (addr 2, period[15:0]) → WR_PH (addr 3, period[31:16]) → RSP.
- START: WR_CTRL (addr 1, data {12'b0, 0, 1, CTRL_CONT, CTRL_ITO}) → RSP.
- STOP: WR_CTRL (addr 1, data {12'b0, 1, 0, CTRL_CONT, CTRL_ITO}) → RSP.
- SNAPSHOT: WR_SNAP (addr 4 write, data 0) → RD_SL (addr 4 read) → RD_SH (addr 5 read; capture readdata into rsp_data[15:0]) → RD_CAP (capture readdata into rsp_data[31:16]) → RSP.
- STATUS: RD_ST (addr 0 read) → RD_CAP (capture readdata[1:0]) → RSP.
- CLEAR: WR_ST (addr 0 write, data 0) → RSP.
- Illegal op: → RSP directly, rsp_err=1, no bus traffic.
- Reads drive chipselect=1, write_n=1. Writes drive chipselect=1, write_n=0.
- In non-bus states: chipselect=0, write_n=1, address=0, writedata=0.
- RSP: rsp_valid=1, holds until rsp_ready, then → IDLE. rsp_data/rsp_err are stable while rsp_valid is high.
- rsp_data and rsp_err are cleared on each accept.

## Timing
- Bus outputs are registered and valid for the whole cycle of their state.
- Latency from the accept edge (cycle 0) to rsp_valid rising:
  - PROGRAM: 3 cycles.
  - START, STOP, CLEAR: 2 cycles.
  - STATUS: 3 cycles.
  - SNAPSHOT: 5 cycles.
  - Illegal op: 1 cycle.
- Minimum command-to-command spacing: latency + 1 cycle (the RSP→IDLE cycle), with rsp_ready held high.
- Reset values: cmd_ready=0 while reset is asserted and 1 from the first cycle in IDLE. All other outputs reset to 0, except write_n=1. State resets to IDLE.
- Reset asserted mid-sequence aborts the sequence immediately; the pending response is discarded and no partial write is retried.
- cmd_valid arriving while busy is ignored (cmd_ready=0); the requester must hold it.

## Configuration
- TIMER_SEQ_IRQ_ACK_EN defined: adds ports irq (in, 1), tick_count (out, 16), tick_pulse (out, 1) and states ACK_WR, ACK_HOLD.
  - In IDLE with irq=1, ACK takes priority over the command port: cmd_ready=0 that cycle.
  - ACK_WR writes addr 0, data 0. ACK_HOLD is one cycle with irq ignored (the slave clears irq after the write), then → IDLE.
  - tick_count increments by 1 per ACK_WR, wraps 0xFFFF→0, resets to 0.
  - tick_pulse is high for the ACK_WR cycle.
  - irq asserted during a command sequence is serviced on return to IDLE.
- Macro undefined: none of these ports or states exist; the timeout flag is cleared only via CLEAR.

## Structure
- timer_seq_pkg contains:
  - the op encoding enum;
  - the state enum;
  - register address constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5);
  - control bit positions (ITO=0, CONT=1, START=2, STOP=3).
- Single module with no sub-module; the FSM and capture registers are too tightly coupled to split usefully.

## Test plan
- PROGRAM with period 0x0001_86A0, against a slave model → writes addr2=0x86A0, then addr3=0x0001, on consecutive cycles; rsp_valid at cycle 3; rsp_data=0.
- START, with defaults → one write addr1=0x0007; rsp at cycle 2. STOP → one write addr1=0x000B.
- SNAPSHOT with slave counter=0x0001_2345 → write addr4, then reads addr4 and addr5; rsp_data=0x0001_2345 at cycle 5.
- STATUS with running=1 and timeout=1, with rsp_ready held low 4 cycles → rsp_data=3 held stable; cmd_ready=0 until 1 cycle after rsp_ready.
- Illegal op 7 → no chipselect; rsp_err=1 at cycle 1. Reset asserted in RD_SH → outputs return to reset values; no rsp_valid.
- (TIMER_SEQ_IRQ_ACK_EN) irq and cmd_valid both high in IDLE → addr0 write first; tick_count 0xFFFF→0; command accepted after ACK_HOLD.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared encodings for the interval-timer sequencing master.
// Optional IRQ-ack states exist only with TIMER_SEQ_IRQ_ACK_EN defined.
package timer_seq_pkg;

   typedef enum logic [2:0] {
      OP_PROGRAM  = 3'd0,
      OP_START    = 3'd1,
      OP_STOP     = 3'd2,
      OP_SNAPSHOT = 3'd3,
      OP_STATUS   = 3'd4,
      OP_CLEAR    = 3'd5
   } op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_PL,
      S_WR_PH,
      S_WR_CTRL,
      S_WR_SNAP,
      S_RD_SL,
      S_RD_SH,
      S_RD_CAP,
      S_RD_ST,
      S_WR_ST,
      S_RSP
`ifdef TIMER_SEQ_IRQ_ACK_EN
      , S_ACK_WR
      , S_ACK_HOLD
`endif
   } state_e;

   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_CONTROL = 3'd1;
   localparam logic [2:0] REG_PERIODL = 3'd2;
   localparam logic [2:0] REG_PERIODH = 3'd3;
   localparam logic [2:0] REG_SNAPL   = 3'd4;
   localparam logic [2:0] REG_SNAPH   = 3'd5;

   localparam int CB_ITO   = 0;
   localparam int CB_CONT  = 1;
   localparam int CB_START = 2;
   localparam int CB_STOP  = 3;

   function automatic logic [15:0] ctrl_word(input logic start,
                                             input logic cont,
                                             input logic ito);
      logic [15:0] w;
      w = '0;
      w[CB_ITO]   = ito;
      w[CB_CONT]  = cont;
      w[CB_START] = start;
      w[CB_STOP]  = !start;
      return w;
   endfunction

   // Illegal opcodes go straight to the response state.
   function automatic state_e first_state(input logic [2:0] op);
      state_e s;
      unique case (op)
         OP_PROGRAM:          s = S_WR_PL;
         OP_START, OP_STOP:   s = S_WR_CTRL;
         OP_SNAPSHOT:         s = S_WR_SNAP;
         OP_STATUS:           s = S_RD_ST;
         OP_CLEAR:            s = S_WR_ST;
         default:             s = S_RSP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/timer_seq_master.sv
// Avalon-MM master expanding one-shot timer commands into register sequences.
// Define TIMER_SEQ_IRQ_ACK_EN to add autonomous IRQ acknowledge (irq/tick ports).
module timer_seq_master
   import timer_seq_pkg::*;
#(
   parameter logic CTRL_CONT = 1'b1,
   parameter logic CTRL_ITO  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_period,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [2:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic [15:0] writedata,
`ifdef TIMER_SEQ_IRQ_ACK_EN
   input  logic        irq,
   output logic [15:0] tick_count,
   output logic        tick_pulse,
`endif
   input  logic [15:0] readdata
);

   state_e      state;
   state_e      state_nxt;
   logic [2:0]  op_q;
   logic [2:0]  op_sel;
   logic [15:0] period_hi_q;
   logic        accept;
   logic        irq_block;
   logic        bus_cs;
   logic        bus_we;
   logic [2:0]  bus_addr;
   logic [15:0] bus_wd;

`ifdef TIMER_SEQ_IRQ_ACK_EN
   assign irq_block = irq;
`else
   assign irq_block = 1'b0;
`endif

   assign cmd_ready = !reset && (state == S_IDLE) && !irq_block;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_nxt = state;
      bus_cs    = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = REG_STATUS;
      bus_wd    = '0;
      op_sel    = (state == S_IDLE) ? cmd_op : op_q;

      unique case (state)
         S_IDLE: begin
`ifdef TIMER_SEQ_IRQ_ACK_EN
            if (irq) state_nxt = S_ACK_WR;
            else
`endif
            if (accept) state_nxt = first_state(op_sel);
         end
         S_WR_PL:    state_nxt = S_WR_PH;
         S_WR_PH:    state_nxt = S_RSP;
         S_WR_CTRL:  state_nxt = S_RSP;
         S_WR_SNAP:  state_nxt = S_RD_SL;
         S_RD_SL:    state_nxt = S_RD_SH;
         S_RD_SH:    state_nxt = S_RD_CAP;
         S_RD_CAP:   state_nxt = S_RSP;
         S_RD_ST:    state_nxt = S_RD_CAP;
         S_WR_ST:    state_nxt = S_RSP;
         S_RSP:      if (rsp_ready) state_nxt = S_IDLE;
`ifdef TIMER_SEQ_IRQ_ACK_EN
         S_ACK_WR:   state_nxt = S_ACK_HOLD;
         S_ACK_HOLD: state_nxt = S_IDLE;
`endif
         default:    state_nxt = S_IDLE;
      endcase

      // Bus signals are decoded from the next state so the registered
      // outputs line up with the cycle the FSM spends in that state.
      unique case (state_nxt)
         S_WR_PL: begin
            bus_cs   = 1'b1;
            bus_we   = 1'b1;
            bus_addr = REG_PERIODL;
            bus_wd   = cmd_period[15:0];
         end
         S_WR_PH: begin
            bus_cs   = 1'b1;
            bus_we   = 1'b1;
            bus_addr = REG_PERIODH;
            bus_wd   = period_hi_q;
         end
         S_WR_CTRL: begin
            bus_cs   = 1'b1;
            bus_we   = 1'b1;
            bus_addr = REG_CONTROL;
            bus_wd   = ctrl_word(op_sel == OP_START, CTRL_CONT, CTRL_ITO);
         end
         S_WR_SNAP: begin
            bus_cs   = 1'b1;
            bus_we   = 1'b1;
            bus_addr = REG_SNAPL;
         end
         S_RD_SL: begin
            bus_cs   = 1'b1;
            bus_addr = REG_SNAPL;
         end
         S_RD_SH: begin
            bus_cs   = 1'b1;
            bus_addr = REG_SNAPH;
         end
         S_RD_ST: begin
            bus_cs   = 1'b1;
            bus_addr = REG_STATUS;
         end
`ifdef TIMER_SEQ_IRQ_ACK_EN
         S_ACK_WR,
`endif
         S_WR_ST: begin
            bus_cs   = 1'b1;
            bus_we   = 1'b1;
            bus_addr = REG_STATUS;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         op_q        <= OP_PROGRAM;
         period_hi_q <= '0;
         address     <= '0;
         chipselect  <= 1'b0;
         write_n     <= 1'b1;
         writedata   <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state      <= state_nxt;
         address    <= bus_addr;
         chipselect <= bus_cs;
         write_n    <= !bus_we;
         writedata  <= bus_wd;
         rsp_valid  <= (state_nxt == S_RSP);
         if (accept) begin
            op_q        <= cmd_op;
            period_hi_q <= cmd_period[31:16];
            rsp_data    <= '0;
            rsp_err     <= (cmd_op > OP_CLEAR);
         end
         // Read data lags the address by one cycle.
         if (state == S_RD_SH) rsp_data[15:0] <= readdata;
         if (state == S_RD_CAP) begin
            if (op_q == OP_SNAPSHOT) rsp_data[31:16] <= readdata;
            else rsp_data <= {30'b0, readdata[1:0]};
         end
      end
   end

`ifdef TIMER_SEQ_IRQ_ACK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_count <= '0;
         tick_pulse <= 1'b0;
      end else begin
         tick_pulse <= (state_nxt == S_ACK_WR);
         if (state_nxt == S_ACK_WR) tick_count <= tick_count + 16'd1;
      end
   end
`endif

endmodule
